// File: rtl/wb_burst_master_if.sv
// Wishbone-style bus between wb_burst_master and a slave.
//   m_addr_o  word address          m_dat_o  write data
//   m_tag_o   cycle type            m_stb_o  strobe
//   m_we_o    write enable          m_dat_i  read data (from slave)
//   m_ack_i   acknowledge (from slave)
interface wb_burst_master_if #(
  parameter int Dw   = 32,
  parameter int Aw   = 10,
  parameter int TAGw = 3
);
  logic [Aw-1:0]   m_addr_o;
  logic [Dw-1:0]   m_dat_o;
  logic [TAGw-1:0] m_tag_o;
  logic            m_stb_o;
  logic            m_we_o;
  logic [Dw-1:0]   m_dat_i;
  logic            m_ack_i;

  modport master (
    output m_addr_o, m_dat_o, m_tag_o, m_stb_o, m_we_o,
    input  m_dat_i, m_ack_i
  );

  modport slave (
    input  m_addr_o, m_dat_o, m_tag_o, m_stb_o, m_we_o,
    output m_dat_i, m_ack_i
  );
endinterface

// File: rtl/wb_burst_master.sv
// Command-driven bus master issuing classic or incrementing-burst cycles.
// Ports:
//   clk, reset                 clock, async active-high reset
//   cmd_valid/cmd_ready        command handshake (we, burst, addr, len)
//   wr_dat_i/wr_valid/wr_ready write data stream, one word per acked beat
//   rd_dat_o/rd_valid/rd_ready read data stream out of a 2-entry FIFO
//   busy_o                     command in progress
//   done_o                     one-cycle completion pulse
//   bus                        master side of wb_burst_master_if
module wb_burst_master #(
  parameter int Dw   = 32,
  parameter int Aw   = 10,
  parameter int TAGw = 3,
  parameter int Lw   = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_we,
  input  logic          cmd_burst,
  input  logic [Aw-1:0] cmd_addr,
  input  logic [Lw-1:0] cmd_len,
  input  logic [Dw-1:0] wr_dat_i,
  input  logic          wr_valid,
  output logic          wr_ready,
  output logic [Dw-1:0] rd_dat_o,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic          busy_o,
  output logic          done_o,
  wb_burst_master_if.master bus
);

  localparam logic [TAGw-1:0] TagClassic = TAGw'(3'b000);
  localparam logic [TAGw-1:0] TagIncr    = TAGw'(3'b010);
  localparam logic [TAGw-1:0] TagEnd     = TAGw'(3'b111);

  typedef enum logic [2:0] {IDLE, CLASSIC, BURST, DRAIN, DONE} state_t;

  state_t        state_q, state_d;
  logic          we_q, burst_q;
  logic [Aw-1:0] addr_q;
  logic [Lw-1:0] left_q;      // beats still to complete
  logic          inflight_q;  // burst read beat issued last cycle, data due now

  logic [Dw-1:0] fifo_mem [2];
  logic          wr_ptr_q, rd_ptr_q;
  logic [1:0]    fifo_cnt_q;

  logic active, last_beat, pop, push, room, beat_done;

  assign cmd_ready = (state_q == IDLE);
  assign busy_o    = (state_q != IDLE);
  assign done_o    = (state_q == DONE);
  assign rd_valid  = (fifo_cnt_q != 2'd0);
  assign rd_dat_o  = fifo_mem[rd_ptr_q];
  assign active    = (state_q == CLASSIC) || (state_q == BURST);
  assign last_beat = (left_q == Lw'(1));
  assign pop       = rd_valid && rd_ready;

  // A read beat may issue only if the FIFO can absorb it together with any
  // word already in flight; a pop in this cycle frees one slot.
  assign room = ({1'b0, fifo_cnt_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});

  // Bus outputs are decoded from state so reset clears them without a clock.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    bus.m_stb_o  = 1'b0;
    bus.m_we_o   = 1'b0;
    bus.m_dat_o  = '0;
    bus.m_tag_o  = '0;
    bus.m_addr_o = addr_q;
    if (active) begin
      bus.m_stb_o = we_q ? wr_valid : room;
      bus.m_we_o  = we_q;
      bus.m_dat_o = we_q ? wr_dat_i : '0;
      if (!burst_q)      bus.m_tag_o = TagClassic;
      else if (last_beat) bus.m_tag_o = TagEnd;
      else               bus.m_tag_o = TagIncr;
    end
  end

  always_comb begin
    beat_done = bus.m_stb_o && bus.m_ack_i;
    wr_ready  = beat_done && we_q;
    // Classic reads capture in the ack cycle; burst reads one cycle later.
    push      = (state_q == CLASSIC && beat_done && !we_q) || inflight_q;
    state_d   = state_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_len == '0)  state_d = DONE;
          else if (cmd_burst) state_d = BURST;
          else                state_d = CLASSIC;
        end
      end
      CLASSIC: if (beat_done && last_beat) state_d = DONE;
      BURST:   if (beat_done && last_beat) state_d = we_q ? DONE : DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      burst_q    <= 1'b0;
      addr_q     <= '0;
      left_q     <= '0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      fifo_cnt_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      inflight_q <= (state_q == BURST) && beat_done && !we_q;
      if (state_q == IDLE && cmd_valid) begin
        we_q    <= cmd_we;
        burst_q <= cmd_burst;
        addr_q  <= cmd_addr;
        left_q  <= cmd_len;
      end else if (beat_done) begin
        addr_q <= addr_q + Aw'(1);
        left_q <= left_q - Lw'(1);
      end
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      unique case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // NOTE: FIFO storage is not reset; the occupancy count alone decides
  // validity, so stale words are never presented.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= bus.m_dat_i;
  end

endmodule

// File: tb/tb_wb_burst_master.sv
module tb_wb_burst_master;
  localparam int Dw = 32, Aw = 10, TAGw = 3, Lw = 8;
  localparam int Depth = 1 << Aw;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          cmd_valid, cmd_ready, cmd_we, cmd_burst;
  logic [Aw-1:0] cmd_addr;
  logic [Lw-1:0] cmd_len;
  logic [Dw-1:0] wr_dat_i, rd_dat_o;
  logic          wr_valid, wr_ready, rd_valid, rd_ready, busy_o, done_o;

  wb_burst_master_if #(.Dw(Dw), .Aw(Aw), .TAGw(TAGw)) bus ();

  wb_burst_master #(.Dw(Dw), .Aw(Aw), .TAGw(TAGw), .Lw(Lw)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_burst(cmd_burst), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_dat_i(wr_dat_i), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_dat_o(rd_dat_o), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .busy_o(busy_o), .done_o(done_o), .bus(bus)
  );

  // ---------------- slave model: RAM, classic acks every 2nd cycle,
  // burst acks combinationally, burst read data one cycle late.
  logic [Dw-1:0] ram [Depth];
  logic [Dw-1:0] salt;
  logic          ram_init;
  logic          wait_q, brd_q;
  logic [Dw-1:0] rdat_q;

  function automatic logic [Dw-1:0] init_pat(input int i);
    return salt ^ (Dw'(i) * 32'h9E37_79B1);
  endfunction

  assign bus.m_ack_i = bus.m_stb_o && ((bus.m_tag_o != 3'b000) || (wait_q === 1'b1));
  assign bus.m_dat_i = (brd_q === 1'b1) ? rdat_q : ram[bus.m_addr_o];

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < Depth; i++) ram[i] <= init_pat(i);
      wait_q <= 1'b0;
      brd_q  <= 1'b0;
    end else begin
      if (bus.m_stb_o && bus.m_ack_i && bus.m_we_o) ram[bus.m_addr_o] <= bus.m_dat_o;
      wait_q <= bus.m_stb_o && (bus.m_tag_o == 3'b000) && !bus.m_ack_i;
      rdat_q <= ram[bus.m_addr_o];
      brd_q  <= bus.m_stb_o && !bus.m_we_o && (bus.m_tag_o != 3'b000);
    end
  end

  // ---------------- reference model and per-command logs
  logic [Dw-1:0] ref_ram [Depth];
  logic [Dw-1:0] wdata[$];
  logic [Dw-1:0] got[$];
  logic [Aw-1:0] q_addr[$];
  logic [2:0]    q_tag[$];
  int            q_cyc[$];
  int  n_cmp = 0, n_err = 0;
  int  cyc, acc_cyc, done_cyc, first_stb, last_stb, wr_idx;
  int  n_stb, n_done, n_stall_stb, n_gap, n_mirror_err;
  bit  we_cur, burst_cur, rrand_cur;
  int  len_cur, wmode_cur, rhold_cur;
  logic [Aw-1:0] addr_cur;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample mid-cycle at negedge, drive just after posedge.
  task automatic step();
    int n;
    @(negedge clk);
    cyc++;
    if (cmd_valid && cmd_ready && acc_cyc < 0) acc_cyc = cyc;
    if (we_cur && busy_o && !done_o && q_addr.size() < len_cur && wr_valid !== bus.m_stb_o)
      n_mirror_err++;
    if (bus.m_stb_o) begin
      n_stb++;
      if (first_stb < 0) first_stb = cyc;
      last_stb = cyc;
      if (!rd_ready) n_stall_stb++;
    end
    if (bus.m_stb_o && bus.m_ack_i) begin
      q_addr.push_back(bus.m_addr_o);
      q_tag.push_back(bus.m_tag_o);
      q_cyc.push_back(cyc);
    end
    if (!rd_ready && !rd_valid && busy_o && acc_cyc >= 0 && cyc >= acc_cyc + 3) n_gap++;
    if (wr_ready) wr_idx++;
    if (rd_valid && rd_ready) got.push_back(rd_dat_o);
    if (done_o) begin n_done++; done_cyc = cyc; end
    @(posedge clk);
    #1;
    n = cyc + 1;
    if (acc_cyc >= 0) cmd_valid = 1'b0;
    if (acc_cyc < 0)         wr_valid = 1'b0;
    else if (wmode_cur == 0) wr_valid = 1'b1;
    else if (wmode_cur == 1) wr_valid = ((n - acc_cyc) % 2 == 1);
    else                     wr_valid = 1'($urandom_range(0, 1));
    wr_dat_i = (wr_idx < len_cur) ? wdata[wr_idx] : '0;
    if (n_done > 0)                                rd_ready = 1'b1;
    else if (acc_cyc < 0 || n - acc_cyc <= rhold_cur) rd_ready = 1'b0;
    else if (rrand_cur)                            rd_ready = 1'($urandom_range(0, 1));
    else                                           rd_ready = 1'b1;
  endtask

  task automatic start_cmd(input bit we, input bit burst, input logic [Aw-1:0] addr,
                           input int len, input int wmode, input int rhold, input bit rrand,
                           input bit use_seq, input logic [Dw-1:0] base);
    wdata.delete(); got.delete(); q_addr.delete(); q_tag.delete(); q_cyc.delete();
    cyc = 0; acc_cyc = -1; done_cyc = -1; first_stb = -1; last_stb = -1; wr_idx = 0;
    n_stb = 0; n_done = 0; n_stall_stb = 0; n_gap = 0; n_mirror_err = 0;
    we_cur = we; burst_cur = burst; addr_cur = addr; len_cur = len;
    wmode_cur = wmode; rhold_cur = rhold; rrand_cur = rrand;
    for (int i = 0; i < len; i++) wdata.push_back(use_seq ? base + Dw'(i) : $urandom);
    cmd_we = we; cmd_burst = burst; cmd_addr = addr; cmd_len = Lw'(len);
    cmd_valid = 1'b1; wr_valid = 1'b0; rd_ready = 1'b0;
    wr_dat_i = (len > 0) ? wdata[0] : '0;
  endtask

  task automatic run_cmd(input bit we, input bit burst, input logic [Aw-1:0] addr,
                         input int len, input int wmode, input int rhold, input bit rrand,
                         input bit use_seq, input logic [Dw-1:0] base);
    int k;
    logic [Aw-1:0] a;
    start_cmd(we, burst, addr, len, wmode, rhold, rrand, use_seq, base);
    k = 0;
    while (!(n_done > 0 && got.size() == (we ? 0 : len)) && k < 600) begin
      step();
      k++;
    end
    chk("finished_in_budget", k < 600, 1'b1);
    chk("done_pulses", n_done, 1);
    chk("ack_count", q_addr.size(), len);
    chk("ready_after_done", cmd_ready, 1'b1);
    for (int i = 0; i < q_addr.size() && i < len; i++) begin
      a = addr + Aw'(i);
      chk("beat_addr", q_addr[i], a);
      chk("beat_tag", q_tag[i], !burst ? 3'b000 : (i == len - 1) ? 3'b111 : 3'b010);
    end
    if (we) begin
      chk("wr_mirror", n_mirror_err, 0);
      for (int i = 0; i < len; i++) begin
        a = addr + Aw'(i);
        ref_ram[a] = wdata[i];
        chk("ram_word", ram[a], ref_ram[a]);
      end
    end else begin
      chk("rd_word_count", got.size(), len);
      for (int i = 0; i < got.size() && i < len; i++) begin
        a = addr + Aw'(i);
        chk("rd_word", got[i], ref_ram[a]);
      end
    end
  endtask

  initial begin
    salt = $urandom;
    for (int i = 0; i < Depth; i++) ref_ram[i] = init_pat(i);
    ram_init = 1'b1; reset = 1'b1;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_burst = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_dat_i = '0; wr_valid = 1'b0; rd_ready = 1'b0;
    we_cur = 1'b0; len_cur = 0; wmode_cur = 0; rhold_cur = 0; rrand_cur = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stb", bus.m_stb_o, 1'b0);
    chk("rst_we", bus.m_we_o, 1'b0);
    chk("rst_tag", bus.m_tag_o, 3'b000);
    chk("rst_addr", bus.m_addr_o, '0);
    chk("rst_dat", bus.m_dat_o, '0);
    chk("rst_flags", {wr_ready, rd_valid, done_o, busy_o}, 4'b0000);
    ram_init = 1'b0; reset = 1'b0;
    #1 chk("ready_after_reset", cmd_ready, 1'b1);
    @(posedge clk); #1;

    // Classic write wrapping the top of the address space.
    run_cmd(1'b1, 1'b0, 10'h3FE, 4, 0, 0, 1'b0, 1'b1, 32'hA0);
    for (int i = 1; i < q_cyc.size(); i++) chk("classic_ack_spacing", q_cyc[i] - q_cyc[i-1], 2);

    // Burst read, reader always ready.
    run_cmd(1'b0, 1'b1, 10'h010, 8, 0, 0, 1'b0, 1'b0, '0);
    chk("burst_stb_cycles", n_stb, 8);
    chk("burst_stb_contiguous", last_stb - first_stb, 7);
    chk("drain_one_cycle", done_cyc - last_stb, 2);

    // Burst read with the reader stalled for 10 cycles.
    run_cmd(1'b0, 1'b1, 10'h100, 8, 0, 10, 1'b0, 1'b0, '0);
    chk("stall_beats", n_stall_stb, 2);
    chk("stall_rd_valid_gaps", n_gap, 0);

    // Zero-length command.
    run_cmd(1'b0, 1'b0, 10'h055, 0, 0, 0, 1'b0, 1'b0, '0);
    chk("len0_no_stb", n_stb, 0);
    chk("len0_done_latency", done_cyc - acc_cyc, 1);

    // Burst write with wr_valid toggling.
    run_cmd(1'b1, 1'b1, 10'h200, 6, 1, 0, 1'b0, 1'b0, '0);
    chk("toggle_stb_eq_acks", n_stb, 6);

    // Reset on the third beat of a burst read.
    start_cmd(1'b0, 1'b1, 10'h040, 8, 0, 0, 1'b0, 1'b0, '0);
    for (int k = 0; k < 50 && q_addr.size() < 2; k++) step();
    chk("pre_reset_acks", q_addr.size(), 2);
    #1 chk("third_beat_issued", bus.m_stb_o, 1'b1);
    reset = 1'b1;
    #1;
    chk("abort_stb", bus.m_stb_o, 1'b0);
    chk("abort_rd_valid", rd_valid, 1'b0);
    chk("abort_busy", busy_o, 1'b0);
    repeat (3) step();
    reset = 1'b0;
    #1 chk("ready_after_abort", cmd_ready, 1'b1);
    repeat (4) step();
    chk("abort_no_done", n_done, 0);
    run_cmd(1'b0, 1'b0, 10'h040, 3, 0, 0, 1'b0, 1'b0, '0);

    // Randomized commands against the reference RAM.
    for (int t = 0; t < 12; t++) begin
      run_cmd(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), Aw'($urandom),
              $urandom_range(0, 12), $urandom_range(0, 2), $urandom_range(0, 5),
              1'($urandom_range(0, 1)), 1'b0, '0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
